// File: rtl/loop_nest_agu.sv
// Nested-loop index/address generator: odometer indices (level 0 innermost),
// per-level stride accumulators, and a valid/ready beat stream with done/abort.
module loop_nest_agu #(
  parameter int unsigned NDEPTH = 3,
  parameter int unsigned IDXDW  = 11,
  parameter int unsigned STRDW  = 12,
  parameter int unsigned ADDRDW = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  input  logic                           i_abort,
  input  logic [NDEPTH-1:0][IDXDW-1:0]   i_loopSize,
  input  logic [NDEPTH-1:0][STRDW-1:0]   i_stride,
  input  logic [ADDRDW-1:0]              i_base,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [NDEPTH-1:0][IDXDW-1:0]   o_loopIdx,
  output logic [ADDRDW-1:0]              o_addr,
  output logic [NDEPTH-1:0]              o_loopEnd,
  output logic                           o_last,
  output logic                           o_busy,
  output logic                           o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NDEPTH-1:0][IDXDW-1:0]  size_q, size_d;
  logic [NDEPTH-1:0][STRDW-1:0]  stride_q;
  logic [ADDRDW-1:0]             base_q, base_d;
  logic [NDEPTH-1:0][ADDRDW-1:0] acc_q, acc_d, acc_adv;
  logic [NDEPTH-1:0][IDXDW-1:0]  idx_d, idx_adv;
  logic [NDEPTH-1:0]             end_d;
  logic [ADDRDW-1:0]             addr_d;
  logic                          load, adv, any_zero, fire, carry;

  assign fire = o_valid && i_ready;

  // An empty nest (any zero trip count) skips straight to DONE.
  always_comb begin
    any_zero = 1'b0;
    for (int unsigned i = 0; i < NDEPTH; i++) begin
      if (i_loopSize[i] == '0) any_zero = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          load    = 1'b1;
          state_d = any_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (fire) begin
          adv = 1'b1;
          if (o_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Odometer step: a level moves only when every lower level wraps.
  always_comb begin
    carry   = 1'b1;
    idx_adv = o_loopIdx;
    acc_adv = acc_q;
    for (int unsigned i = 0; i < NDEPTH; i++) begin
      if (carry) begin
        if (o_loopEnd[i]) begin
          idx_adv[i] = '0;
          acc_adv[i] = '0;
        end else begin
          idx_adv[i] = o_loopIdx[i] + IDXDW'(1);
          acc_adv[i] = acc_q[i] + ADDRDW'(stride_q[i]);
        end
      end
      carry = carry && o_loopEnd[i];
    end
  end

  // Next-state datapath; loop-end flags and address are precomputed so outputs stay registered.
  always_comb begin
    size_d = load ? i_loopSize : size_q;
    base_d = load ? i_base : base_q;
    idx_d  = o_loopIdx;
    acc_d  = acc_q;
    if (load) begin
      idx_d = '0;
      acc_d = '0;
    end else if (adv) begin
      idx_d = idx_adv;
      acc_d = acc_adv;
    end
    addr_d = base_d;
    end_d  = '0;
    for (int unsigned i = 0; i < NDEPTH; i++) begin
      end_d[i] = (idx_d[i] == size_d[i] - IDXDW'(1));
      addr_d   = addr_d + acc_d[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      size_q    <= '0;
      stride_q  <= '0;
      base_q    <= '0;
      acc_q     <= '0;
      o_loopIdx <= '0;
      o_loopEnd <= '0;
      o_last    <= 1'b0;
      o_addr    <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      size_q    <= size_d;
      if (load) stride_q <= i_stride;
      base_q    <= base_d;
      acc_q     <= acc_d;
      o_loopIdx <= idx_d;
      o_loopEnd <= end_d;
      o_last    <= &end_d;
      o_addr    <= addr_d;
      o_valid   <= (state_d == RUN);
      o_busy    <= (state_d != IDLE);
      o_done    <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_loop_nest_agu.sv
// Directed bench for loop_nest_agu: a table of configs checked beat-by-beat
// against a nested-loop reference, plus abort and reset sequences.
module tb_loop_nest_agu;

  localparam int unsigned NDEPTH = 3;
  localparam int unsigned IDXDW  = 11;
  localparam int unsigned STRDW  = 12;
  localparam int unsigned ADDRDW = 16;

  typedef logic [NDEPTH-1:0][IDXDW-1:0] idx_t;
  typedef logic [NDEPTH-1:0][STRDW-1:0] str_t;

  typedef struct {
    idx_t              size;
    str_t              stride;
    logic [ADDRDW-1:0] base;
    int                ready_mode;
    int                poke_beat;
    int                exp_beats;
    logic [ADDRDW-1:0] exp_first;
    logic [ADDRDW-1:0] exp_last;
  } vec_t;

  logic              i_clk = 1'b0;
  logic              i_rst, i_start, i_abort, i_ready;
  idx_t              i_loopSize;
  str_t              i_stride;
  logic [ADDRDW-1:0] i_base;
  logic              o_valid, o_last, o_busy, o_done;
  idx_t              o_loopIdx;
  logic [ADDRDW-1:0] o_addr;
  logic [NDEPTH-1:0] o_loopEnd;

  int checks   = 0;
  int failures = 0;

  loop_nest_agu #(.NDEPTH(NDEPTH), .IDXDW(IDXDW), .STRDW(STRDW), .ADDRDW(ADDRDW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_loopSize(i_loopSize), .i_stride(i_stride), .i_base(i_base),
    .o_valid(o_valid), .i_ready(i_ready), .o_loopIdx(o_loopIdx), .o_addr(o_addr),
    .o_loopEnd(o_loopEnd), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mkvec(input int s0, input int s1, input int s2,
                                 input int t0, input int t1, input int t2,
                                 input int base, input int rmode, input int poke,
                                 input int beats, input int first, input int last);
    vec_t v;
    v.size[0] = IDXDW'(s0);   v.size[1] = IDXDW'(s1);   v.size[2] = IDXDW'(s2);
    v.stride[0] = STRDW'(t0); v.stride[1] = STRDW'(t1); v.stride[2] = STRDW'(t2);
    v.base = ADDRDW'(base);
    v.ready_mode = rmode;
    v.poke_beat = poke;
    v.exp_beats = beats;
    v.exp_first = ADDRDW'(first);
    v.exp_last = ADDRDW'(last);
    return v;
  endfunction

  task automatic run_case(input vec_t v, input string nm);
    idx_t              m_idx[$];
    logic [ADDRDW-1:0] m_addr[$];
    logic [NDEPTH-1:0] m_end[$];
    idx_t              h_idx;
    logic [ADDRDW-1:0] h_addr, first_addr, last_addr;
    logic [NDEPTH-1:0] h_end;
    logic              h_last, held, rdy, done_seen, poked;
    int                k, last_fire_c;

    // Reference beat list straight from the loop-nest definition.
    for (int a2 = 0; a2 < int'(v.size[2]); a2++)
      for (int a1 = 0; a1 < int'(v.size[1]); a1++)
        for (int a0 = 0; a0 < int'(v.size[0]); a0++) begin
          idx_t e;
          logic [NDEPTH-1:0] en;
          e[0] = IDXDW'(a0); e[1] = IDXDW'(a1); e[2] = IDXDW'(a2);
          en[0] = (a0 == int'(v.size[0]) - 1);
          en[1] = (a1 == int'(v.size[1]) - 1);
          en[2] = (a2 == int'(v.size[2]) - 1);
          m_idx.push_back(e);
          m_end.push_back(en);
          m_addr.push_back(ADDRDW'(int'(v.base) + a0 * int'(v.stride[0])
                                   + a1 * int'(v.stride[1]) + a2 * int'(v.stride[2])));
        end

    i_loopSize = v.size;
    i_stride   = v.stride;
    i_base     = v.base;
    i_start    = 1'b1;
    i_ready    = 1'b0;
    tick();
    i_start = 1'b0;

    k = 0; last_fire_c = -1; held = 1'b0; done_seen = 1'b0; poked = 1'b0;
    first_addr = '0; last_addr = '0;
    h_idx = '0; h_addr = '0; h_end = '0; h_last = 1'b0;
    for (int c = 0; c < 400 && !done_seen; c++) begin
      rdy = (v.ready_mode == 0) ? 1'b1 : (c % 3 == 0);
      i_ready = rdy;
      if (v.poke_beat >= 0 && k == v.poke_beat && !poked) begin
        i_start    = 1'b1;
        i_loopSize = {NDEPTH{IDXDW'(5)}};
        i_stride   = {NDEPTH{STRDW'(77)}};
        i_base     = 16'h1234;
        poked      = 1'b1;
      end else begin
        i_start = 1'b0;
      end
      if (o_done) begin
        done_seen = 1'b1;
        chk({nm, " done_valid"}, 64'(o_valid), 64'd0);
        chk({nm, " done_timing"}, 64'(c), 64'(last_fire_c + 1));
      end else if (o_valid) begin
        chk({nm, " busy_in_run"}, 64'(o_busy), 64'd1);
        if (held) begin
          chk({nm, " stall_idx"}, 64'(o_loopIdx), 64'(h_idx));
          chk({nm, " stall_addr"}, 64'(o_addr), 64'(h_addr));
          chk({nm, " stall_end"}, 64'(o_loopEnd), 64'(h_end));
          chk({nm, " stall_last"}, 64'(o_last), 64'(h_last));
        end
        if (rdy) begin
          if (k < m_idx.size()) begin
            chk({nm, " beat_idx"}, 64'(o_loopIdx), 64'(m_idx[k]));
            chk({nm, " beat_addr"}, 64'(o_addr), 64'(m_addr[k]));
            chk({nm, " beat_end"}, 64'(o_loopEnd), 64'(m_end[k]));
            chk({nm, " beat_last"}, 64'(o_last), 64'(k == m_idx.size() - 1));
          end else begin
            chk({nm, " extra_beat"}, 64'(k), 64'(m_idx.size()));
          end
          if (k == 0) first_addr = o_addr;
          last_addr = o_addr;
          k++;
          last_fire_c = c;
          held = 1'b0;
        end else begin
          h_idx = o_loopIdx; h_addr = o_addr; h_end = o_loopEnd; h_last = o_last;
          held = 1'b1;
        end
      end
      tick();
    end
    i_start = 1'b0;
    i_ready = 1'b0;
    chk({nm, " done_seen"}, 64'(done_seen), 64'd1);
    chk({nm, " beats"}, 64'(k), 64'(v.exp_beats));
    if (v.exp_beats > 0) begin
      chk({nm, " first_addr"}, 64'(first_addr), 64'(v.exp_first));
      chk({nm, " last_addr"}, 64'(last_addr), 64'(v.exp_last));
    end
    chk({nm, " post_done"}, 64'(o_done), 64'd0);
    chk({nm, " post_busy"}, 64'(o_busy), 64'd0);
    chk({nm, " post_valid"}, 64'(o_valid), 64'd0);
  endtask

  vec_t vecs[8];
  string names[8];

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = mkvec(2, 3, 2, 1, 2, 6, 100, 0, -1, 12, 100, 111);
    vecs[1] = mkvec(2, 3, 2, 1, 2, 6, 100, 1, -1, 12, 100, 111);
    vecs[2] = mkvec(4, 0, 3, 1, 1, 1, 50, 0, -1, 0, 0, 0);
    vecs[3] = mkvec(3, 3, 1, 5, 100, 7, 'hFFF0, 0, -1, 9, 'hFFF0, 'h00C2);
    vecs[4] = mkvec(2, 3, 2, 1, 2, 6, 100, 0, 3, 12, 100, 111);
    vecs[5] = mkvec(1, 1, 1, 9, 9, 9, 7, 0, -1, 1, 7, 7);
    vecs[6] = mkvec(1, 4, 1, 3, 'hFFF, 2, 0, 1, -1, 4, 0, 'h2FFD);
    vecs[7] = mkvec(2, 3, 2, 1, 2, 6, 0, 0, -1, 12, 0, 11);
    names = '{"t1_ready", "t2_stall", "t3_empty", "t4_wrap", "t6_start_poke",
              "size_one", "stride_max", "t5_restart"};

    i_rst = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_ready = 1'b0;
    i_loopSize = '0; i_stride = '0; i_base = '0;
    tick();
    tick();
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_idx", 64'(o_loopIdx), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'd0);
    i_rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_case(vecs[i], names[i]);
      tick();
    end

    // T4 hand point: fourth beat is idx {0,1,0}, address wraps to 0x0054.
    i_loopSize = vecs[3].size; i_stride = vecs[3].stride; i_base = vecs[3].base;
    i_start = 1'b1; i_ready = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick(); tick();
    chk("t4_beat4_idx1", 64'(o_loopIdx[1]), 64'd1);
    chk("t4_beat4_idx0", 64'(o_loopIdx[0]), 64'd0);
    chk("t4_beat4_addr", 64'(o_addr), 64'h0054);

    // Abort: still mid-run from above; abort wins over the handshake.
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    i_ready = 1'b0;
    chk("abort_valid", 64'(o_valid), 64'd0);
    chk("abort_busy", 64'(o_busy), 64'd0);
    for (int c = 0; c < 4; c++) begin
      chk("abort_no_done", 64'(o_done), 64'd0);
      tick();
    end

    // T5: abort after five beats, then restart from base 0.
    i_loopSize = vecs[0].size; i_stride = vecs[0].stride; i_base = vecs[0].base;
    i_start = 1'b1; i_ready = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("t5_pre_valid", 64'(o_valid), 64'd1);
      tick();
    end
    chk("t5_sixth_addr", 64'(o_addr), 64'd105);
    i_abort = 1'b1;
    i_ready = 1'b0;
    tick();
    i_abort = 1'b0;
    chk("t5_abort_valid", 64'(o_valid), 64'd0);
    for (int c = 0; c < 3; c++) begin
      chk("t5_no_done", 64'(o_done), 64'd0);
      tick();
    end
    run_case(vecs[7], names[7]);
    tick();

    // T6: synchronous reset in the middle of a run.
    i_loopSize = vecs[0].size; i_stride = vecs[0].stride; i_base = vecs[0].base;
    i_start = 1'b1; i_ready = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t6_pre_addr", 64'(o_addr), 64'd104);
    i_rst = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(o_valid), 64'd0);
    chk("t6_rst_busy", 64'(o_busy), 64'd0);
    chk("t6_rst_done", 64'(o_done), 64'd0);
    chk("t6_rst_idx", 64'(o_loopIdx), 64'd0);
    chk("t6_rst_addr", 64'(o_addr), 64'd0);
    chk("t6_rst_end", 64'(o_loopEnd), 64'd0);
    chk("t6_rst_last", 64'(o_last), 64'd0);
    i_rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("t6_no_done", 64'(o_done), 64'd0);
      chk("t6_idle_valid", 64'(o_valid), 64'd0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
